// File: rtl/program_counter.sv
// Registered program counter for the Hack CPU: reset, stall, jump load and increment,
// with jump reporting. Define PC_HALT_DETECT_EN to build the end-of-program halt detector.
module program_counter #(
  parameter int                ADDR_W     = 15,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_load,
  input  logic              pc_inc,
  input  logic              stall,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              jump_taken,
  output logic [15:0]       jump_count,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [15:0]       COUNT_MAX = 16'hFFFF;

  logic frozen;

`ifdef PC_HALT_DETECT_EN
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ARMED  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

  halt_state_t state, next_state;
  logic        apply_load;
  logic        apply_inc;
  logic        loop_back;
  logic [ADDR_W-1:0] load_addr_next;

  // A loop-back load targets the current PC or the instruction just before it,
  // which is what the @END / 0;JMP idiom produces.
  assign load_addr_next = load_addr + ADDR_ONE;
  assign loop_back      = (load_addr == pc) || (load_addr_next == pc);
  assign apply_load     = !frozen && !stall && pc_load;
  assign apply_inc      = !frozen && !stall && !pc_load && pc_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (apply_load && loop_back) begin
          next_state = ARMED;
        end
      end
      ARMED: begin
        if (apply_load) begin
          next_state = loop_back ? HALTED : RUN;
        end else if (apply_inc) begin
          next_state = RUN;
        end
      end
      HALTED: begin
        next_state = HALTED;
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  always_comb begin
    halted = (state == HALTED);
    frozen = (state == HALTED);
  end
`else
  assign halted = 1'b0;
  assign frozen = 1'b0;
`endif

  // Datapath priority: reset, halt freeze, stall, load, increment, hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_ADDR;
      jump_taken <= 1'b0;
      jump_count <= '0;
    end else if (frozen || stall) begin
      jump_taken <= 1'b0;
    end else if (pc_load) begin
      pc         <= load_addr;
      jump_taken <= 1'b1;
      if (jump_count != COUNT_MAX) begin
        jump_count <= jump_count + 16'd1;
      end
    end else if (pc_inc) begin
      pc         <= pc + ADDR_ONE;
      jump_taken <= 1'b0;
    end else begin
      jump_taken <= 1'b0;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: a directed vector table plus hand-written
// sequences for halt detection, wrap-around loop-back and jump_count saturation.
module tb_program_counter;

`ifdef PC_HALT_DETECT_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        pc_load;
  logic        pc_inc;
  logic        stall;
  logic [14:0] load_addr;
  logic [14:0] pc;
  logic        jump_taken;
  logic [15:0] jump_count;
  logic        halted;

  int checks;
  int errors;

  typedef struct {
    logic        rst;
    logic        ld;
    logic        inc;
    logic        stl;
    logic [14:0] addr;
    logic [14:0] exp_pc;
    logic        exp_jt;
    logic [15:0] exp_jc;
    logic        exp_h;
  } vec_t;

  vec_t vecs[16];

  program_counter #(
    .ADDR_W    (15),
    .RESET_ADDR(15'd0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_load   (pc_load),
    .pc_inc    (pc_inc),
    .stall     (stall),
    .load_addr (load_addr),
    .pc        (pc),
    .jump_taken(jump_taken),
    .jump_count(jump_count),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic ld, input logic inc,
                               input logic stl, input logic [14:0] addr);
    reset     = rst;
    pc_load   = ld;
    pc_inc    = inc;
    stall     = stl;
    load_addr = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [14:0] exp_pc,
                             input logic exp_jt, input logic [15:0] exp_jc,
                             input logic exp_h);
    checks++;
    if (pc !== exp_pc || jump_taken !== exp_jt || jump_count !== exp_jc || halted !== exp_h) begin
      errors++;
      $display("[TB] FAIL %s: got pc=%h jt=%b jc=%h halted=%b, expected pc=%h jt=%b jc=%h halted=%b",
               name, pc, jump_taken, jump_count, halted, exp_pc, exp_jt, exp_jc, exp_h);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    stall     = 1'b0;
    load_addr = '0;

    //            rst   ld    inc   stl   addr       pc         jt    jc       h
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 15'h0000, 15'h0000, 1'b0, 16'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h0001, 1'b0, 16'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h0002, 1'b0, 16'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h0003, 1'b0, 16'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h0004, 1'b0, 16'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h0005, 1'b0, 16'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 15'h0100, 15'h0100, 1'b1, 16'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 15'h0333, 15'h0100, 1'b0, 16'd1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 15'h0120, 15'h0120, 1'b1, 16'd2, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 15'h7FFF, 15'h7FFF, 1'b1, 16'd3, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h0000, 1'b0, 16'd3, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 15'h0055, 15'h0000, 1'b0, 16'd3, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 15'h0000, 15'h0000, 1'b0, 16'd3, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h0001, 1'b0, 16'd3, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 15'h0040, 15'h0040, 1'b1, 16'd4, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 15'h0077, 15'h0000, 1'b0, 16'd0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ld, vecs[i].inc, vecs[i].stl, vecs[i].addr);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_jt,
                  vecs[i].exp_jc, vecs[i].exp_h);
    end

    // Two consecutive loop-back loads halt, then the PC ignores every control but reset.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 15'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0011);
    checkOutput("halt_pre", 15'h0011, 1'b1, 16'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0010);
    checkOutput("halt_arm", 15'h0010, 1'b1, 16'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0010);
    checkOutput("halt_enter", 15'h0010, 1'b1, 16'd3, HD);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 15'h0000);
    checkOutput("halt_inc", HD ? 15'h0010 : 15'h0011, 1'b0, 16'd3, HD);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0300);
    checkOutput("halt_load", HD ? 15'h0010 : 15'h0300, !HD, HD ? 16'd3 : 16'd4, HD);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 15'h0444);
    checkOutput("halt_stall", HD ? 15'h0010 : 15'h0300, 1'b0, HD ? 16'd3 : 16'd4, HD);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 15'h0055);
    checkOutput("halt_reset", 15'h0000, 1'b0, 16'd0, 1'b0);

    // A non-loop load or an increment drops ARMED back to RUN; stall keeps ARMED.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0011);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0010);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0200);
    checkOutput("rearm_nonloop", 15'h0200, 1'b1, 16'd3, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0200);
    checkOutput("rearm_loop", 15'h0200, 1'b1, 16'd4, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 15'h0000);
    checkOutput("rearm_inc", 15'h0201, 1'b0, 16'd4, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0200);
    checkOutput("rearm_after_inc", 15'h0200, 1'b1, 16'd5, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 15'h0200);
    checkOutput("armed_stall", 15'h0200, 1'b0, 16'd5, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0200);
    checkOutput("armed_stall_halt", 15'h0200, 1'b1, 16'd6, HD);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0200);
    checkOutput("repeat_loop", 15'h0200, !HD, HD ? 16'd6 : 16'd7, HD);

    // Loop-back detection wraps: target 0x7FFF seen from PC 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 15'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h7FFF);
    checkOutput("wrap_arm", 15'h7FFF, 1'b1, 16'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h7FFF);
    checkOutput("wrap_halt", 15'h7FFF, 1'b1, 16'd2, HD);

    // Saturation: 65535 loads alternating between two non-loop-back targets.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 15'h0000);
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, (i % 2 == 0) ? 15'h0100 : 15'h0200);
    end
    checkOutput("sat_reach", 15'h0100, 1'b1, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0200);
    checkOutput("sat_hold", 15'h0200, 1'b1, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0100);
    checkOutput("sat_hold2", 15'h0100, 1'b1, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 15'h0000);
    checkOutput("sat_inc", 15'h0101, 1'b0, 16'hFFFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
